// File: rtl/reorder_buffer_pkg.sv
// Shared types, widths and helpers for the reorder buffer and its neighbours
// (issue queue tags, branch-predictor update).
package reorder_buffer_pkg;

    localparam int unsigned ROB_LENGTH      = 16;
    localparam int unsigned ROB_IDX_W       = $clog2(ROB_LENGTH);
    localparam int unsigned INSTR_MEM_IDX_W = 8;
    localparam int unsigned INT_DATA_W      = 32;
    localparam int unsigned ARCH_REG_W      = 5;

    // MSB is the wrap bit; the low ROB_IDX_W bits select the slot.
    typedef logic [ROB_IDX_W:0] rob_tag_t;

    typedef struct packed {
        logic                       valid;
        logic                       done;
        logic [INSTR_MEM_IDX_W-1:0] pc;
        logic [ARCH_REG_W-1:0]      rd;
        logic                       is_branch;
        logic                       pred_taken;
        logic [INSTR_MEM_IDX_W-1:0] pred_target;
        logic                       branch_taken;
        logic [INSTR_MEM_IDX_W-1:0] branch_target;
        logic [INT_DATA_W-1:0]      result;
    } rob_entry_t;

    typedef struct packed {
        logic                       valid;
        rob_tag_t                   rob_idx;
        logic [INSTR_MEM_IDX_W-1:0] pc;
    } iq_entry_t;

    function automatic logic [ROB_IDX_W-1:0] rob_slot(input rob_tag_t tag);
        return tag[ROB_IDX_W-1:0];
    endfunction

    function automatic logic is_mispredict(input rob_entry_t e);
        return e.is_branch &&
               ((e.branch_taken != e.pred_taken) ||
                (e.branch_taken && (e.branch_target != e.pred_target)));
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / commit bundle of the reorder buffer.
// master = surrounding core (drives alloc, writeback, commit_ready); slave = ROB.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                       alloc_valid;
    rob_entry_t                 alloc_entry;
    logic                       alloc_ready;
    rob_tag_t                   alloc_tag;

    logic                       wb_valid;
    rob_tag_t                   wb_tag;
    logic [INT_DATA_W-1:0]      wb_result;
    logic                       wb_branch_taken;
    logic [INSTR_MEM_IDX_W-1:0] wb_branch_target;

    logic                       commit_valid;
    logic                       commit_ready;
    rob_entry_t                 commit_entry;

    logic                       flush;
    logic [INSTR_MEM_IDX_W-1:0] redirect_pc;
    rob_tag_t                   rob_count;
    logic                       rob_empty;
    logic                       rob_full;

    modport master (
        output alloc_valid, alloc_entry,
        input  alloc_ready, alloc_tag,
        output wb_valid, wb_tag, wb_result, wb_branch_taken, wb_branch_target,
        input  commit_valid, commit_entry,
        output commit_ready,
        input  flush, redirect_pc, rob_count, rob_empty, rob_full
    );

    modport slave (
        input  alloc_valid, alloc_entry,
        output alloc_ready, alloc_tag,
        input  wb_valid, wb_tag, wb_result, wb_branch_taken, wb_branch_target,
        output commit_valid, commit_entry,
        input  commit_ready,
        output flush, redirect_pc, rob_count, rob_empty, rob_full
    );

endinterface

// File: rtl/reorder_buffer_ptr.sv
// Wrap-bit circular pointer: increments by one, synchronous clear has priority.
module rob_ptr
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned W = ROB_IDX_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: tail allocation, tagged writeback, head retirement,
// and a registered one-cycle flush with redirect on a mispredicted branch commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave io_rob
);

    rob_entry_t                 r_rob [ROB_LENGTH];
    logic                       r_flush;
    logic [INSTR_MEM_IDX_W-1:0] r_redirect;

    rob_tag_t                   w_head;
    rob_tag_t                   w_tail;
    logic [ROB_IDX_W-1:0]       w_head_idx;
    logic [ROB_IDX_W-1:0]       w_tail_idx;
    logic [ROB_IDX_W-1:0]       w_wb_idx;
    logic                       w_full;
    logic                       w_empty;
    rob_entry_t                 w_head_entry;
    rob_entry_t                 w_alloc_entry;
    logic                       w_alloc_ready;
    logic                       w_alloc_fire;
    logic                       w_commit_valid;
    logic                       w_commit_fire;
    logic                       w_wb_hit;
    logic                       w_mispredict;
    logic [INSTR_MEM_IDX_W-1:0] w_redirect_nxt;

    assign w_head_idx   = rob_slot(w_head);
    assign w_tail_idx   = rob_slot(w_tail);
    assign w_wb_idx     = rob_slot(io_rob.wb_tag);
    assign w_head_entry = r_rob[w_head_idx];

    assign w_empty = (w_head == w_tail);
    assign w_full  = (w_head_idx == w_tail_idx) && (w_head[ROB_IDX_W] != w_tail[ROB_IDX_W]);

    // Handshakes depend on registered state only, never on the other side's ready.
    assign w_alloc_ready  = !rst && !w_full && !r_flush;
    assign w_alloc_fire   = io_rob.alloc_valid && w_alloc_ready;
    assign w_commit_valid = !rst && w_head_entry.valid && w_head_entry.done;
    assign w_commit_fire  = w_commit_valid && io_rob.commit_ready;
    assign w_wb_hit       = io_rob.wb_valid && r_rob[w_wb_idx].valid;
    assign w_mispredict   = w_commit_fire && is_mispredict(w_head_entry);

    assign w_redirect_nxt = w_head_entry.branch_taken ? w_head_entry.branch_target
                                                      : w_head_entry.pc + 8'd1;

    always_comb begin
        w_alloc_entry       = io_rob.alloc_entry;
        w_alloc_entry.valid = 1'b1;
        w_alloc_entry.done  = 1'b0;
    end

    rob_ptr #(
        .W (ROB_IDX_W + 1)
    ) u_head_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_commit_fire),
        .i_clr (w_mispredict),
        .o_ptr (w_head)
    );

    rob_ptr #(
        .W (ROB_IDX_W + 1)
    ) u_tail_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_alloc_fire),
        .i_clr (w_mispredict),
        .o_ptr (w_tail)
    );

    // A mispredict wipes every slot and swallows same-cycle alloc/writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_LENGTH; i++) begin
                r_rob[i] <= '0;
            end
        end else if (w_mispredict) begin
            for (int i = 0; i < ROB_LENGTH; i++) begin
                r_rob[i].valid <= 1'b0;
            end
        end else begin
            if (w_alloc_fire) begin
                r_rob[w_tail_idx] <= w_alloc_entry;
            end
            if (w_wb_hit) begin
                r_rob[w_wb_idx].result        <= io_rob.wb_result;
                r_rob[w_wb_idx].branch_taken  <= io_rob.wb_branch_taken;
                r_rob[w_wb_idx].branch_target <= io_rob.wb_branch_target;
                r_rob[w_wb_idx].done          <= 1'b1;
            end
            if (w_commit_fire) begin
                r_rob[w_head_idx].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush    <= 1'b0;
            r_redirect <= '0;
        end else begin
            r_flush <= w_mispredict;
            if (w_mispredict) begin
                r_redirect <= w_redirect_nxt;
            end
        end
    end

    assign io_rob.alloc_ready  = w_alloc_ready;
    assign io_rob.alloc_tag    = w_tail;
    assign io_rob.commit_valid = w_commit_valid;
    assign io_rob.commit_entry = w_head_entry;
    assign io_rob.flush        = r_flush;
    assign io_rob.redirect_pc  = r_redirect;
    assign io_rob.rob_count    = w_tail - w_head;
    assign io_rob.rob_empty    = w_empty;
    assign io_rob.rob_full     = w_full;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reorder_buffer_if rif ();

    reorder_buffer u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_rob (rif)
    );

    int       n_tests = 0;
    int       n_fail  = 0;
    rob_tag_t exp_tag;
    rob_tag_t t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.alloc_valid      = 1'b0;
        rif.alloc_entry      = '0;
        rif.wb_valid         = 1'b0;
        rif.wb_tag           = '0;
        rif.wb_result        = '0;
        rif.wb_branch_taken  = 1'b0;
        rif.wb_branch_target = '0;
    endtask

    // valid/done set deliberately: the ROB must ignore them on allocation.
    function automatic rob_entry_t mk(input logic [7:0] pc, input logic br,
                                      input logic pt, input logic [7:0] ptgt);
        rob_entry_t e;
        e             = '0;
        e.valid       = 1'b1;
        e.done        = 1'b1;
        e.pc          = pc;
        e.is_branch   = br;
        e.pred_taken  = pt;
        e.pred_target = ptgt;
        return e;
    endfunction

    task automatic alloc(input rob_entry_t e);
        rif.alloc_valid = 1'b1;
        rif.alloc_entry = e;
        #1;
        chk("alloc_ready", rif.alloc_ready, 1);
        chk("alloc_tag", rif.alloc_tag, exp_tag);
        tick();
        exp_tag++;
        rif.alloc_valid = 1'b0;
    endtask

    task automatic wb(input rob_tag_t tag, input logic [31:0] res, input logic tk,
                      input logic [7:0] tgt);
        rif.wb_valid         = 1'b1;
        rif.wb_tag           = tag;
        rif.wb_result        = res;
        rif.wb_branch_taken  = tk;
        rif.wb_branch_target = tgt;
        tick();
        rif.wb_valid = 1'b0;
    endtask

    task automatic commit_one(input logic [7:0] pc, input logic [31:0] res);
        rif.commit_ready = 1'b1;
        #1;
        chk("commit_valid", rif.commit_valid, 1);
        chk("commit_pc", rif.commit_entry.pc, pc);
        chk("commit_result", rif.commit_entry.result, res);
        tick();
        rif.commit_ready = 1'b0;
    endtask

    task automatic batch(input int n, input int pcbase);
        rob_tag_t start;
        start = exp_tag;
        for (int k = 0; k < n; k++) alloc(mk(8'(pcbase + k), 1'b0, 1'b0, 8'h00));
        for (int k = 0; k < n; k++) wb(start + rob_tag_t'(k), 32'(pcbase + k), 1'b0, 8'h00);
        for (int k = 0; k < n; k++) commit_one(8'(pcbase + k), 32'(pcbase + k));
        #1;
        chk("batch_empty", rif.rob_empty, 1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rif.commit_ready = 1'b0;
        exp_tag = '0;
        #1;
        chk("rst_alloc_ready", rif.alloc_ready, 0);
        chk("rst_commit_valid", rif.commit_valid, 0);
        chk("rst_empty", rif.rob_empty, 1);
        chk("rst_full", rif.rob_full, 0);
        chk("rst_count", rif.rob_count, 0);
        chk("rst_flush", rif.flush, 0);
        chk("rst_redirect", rif.redirect_pc, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", rif.alloc_ready, 1);

        // Fill all 16 slots with no commits.
        for (int i = 0; i < 16; i++) alloc(mk(8'(i), 1'b0, 1'b0, 8'h00));
        rif.alloc_valid = 1'b1;
        rif.alloc_entry = mk(8'hEE, 1'b0, 1'b0, 8'h00);
        #1;
        chk("full_flag", rif.rob_full, 1);
        chk("full_ready", rif.alloc_ready, 0);
        chk("full_count", rif.rob_count, 16);
        chk("full_no_commit", rif.commit_valid, 0);
        tick();
        idle();
        #1;
        chk("full_17th_rejected", rif.rob_count, 16);
        for (int i = 0; i < 16; i++) wb(rob_tag_t'(i), 32'h100 + 32'(i), 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) commit_one(8'(i), 32'h100 + 32'(i));
        #1;
        chk("drain_empty", rif.rob_empty, 1);

        // Wrap: tags 0x10..0x1F, 0x00..0x0F, 0x10..0x17.
        batch(16, 'h60);
        batch(16, 'h80);
        batch(8, 'hA0);

        // Out-of-order writeback, in-order commit.
        t = exp_tag;
        alloc(mk(8'h50, 1'b0, 1'b0, 8'h00));
        alloc(mk(8'h51, 1'b0, 1'b0, 8'h00));
        alloc(mk(8'h52, 1'b0, 1'b0, 8'h00));
        rif.commit_ready     = 1'b1;
        rif.wb_valid         = 1'b1;
        rif.wb_tag           = t + rob_tag_t'(2);
        rif.wb_result        = 32'hC;
        #1;
        chk("ooo_wait_c", rif.commit_valid, 0);
        tick();
        rif.wb_tag    = t;
        rif.wb_result = 32'hA;
        #1;
        chk("ooo_wait_a", rif.commit_valid, 0);
        tick();
        rif.wb_tag    = t + rob_tag_t'(1);
        rif.wb_result = 32'hB;
        #1;
        chk("ooo_valid_a", rif.commit_valid, 1);
        chk("ooo_res_a", rif.commit_entry.result, 32'hA);
        tick();
        rif.wb_valid = 1'b0;
        #1;
        chk("ooo_valid_b", rif.commit_valid, 1);
        chk("ooo_res_b", rif.commit_entry.result, 32'hB);
        tick();
        #1;
        chk("ooo_valid_c", rif.commit_valid, 1);
        chk("ooo_res_c", rif.commit_entry.result, 32'hC);
        tick();
        rif.commit_ready = 1'b0;
        #1;
        chk("ooo_empty", rif.rob_empty, 1);

        // Simultaneous alloc and commit keeps the count.
        t = exp_tag;
        alloc(mk(8'h70, 1'b0, 1'b0, 8'h00));
        wb(t, 32'h70, 1'b0, 8'h00);
        rif.alloc_valid  = 1'b1;
        rif.alloc_entry  = mk(8'h71, 1'b0, 1'b0, 8'h00);
        rif.commit_ready = 1'b1;
        #1;
        chk("simul_count_pre", rif.rob_count, 1);
        chk("simul_commit_valid", rif.commit_valid, 1);
        chk("simul_tag", rif.alloc_tag, t + rob_tag_t'(1));
        tick();
        exp_tag++;
        idle();
        rif.commit_ready = 1'b0;
        #1;
        chk("simul_count_post", rif.rob_count, 1);
        wb(t + rob_tag_t'(1), 32'h71, 1'b0, 8'h00);
        commit_one(8'h71, 32'h71);

        // Mispredicted taken branch with two younger entries.
        t = exp_tag;
        alloc(mk(8'h20, 1'b1, 1'b0, 8'h21));
        alloc(mk(8'h21, 1'b0, 1'b0, 8'h00));
        alloc(mk(8'h22, 1'b0, 1'b0, 8'h00));
        wb(t, 32'h0, 1'b1, 8'h40);
        wb(t + rob_tag_t'(1), 32'h21, 1'b0, 8'h00);
        wb(t + rob_tag_t'(2), 32'h22, 1'b0, 8'h00);
        rif.commit_ready = 1'b1;
        rif.alloc_valid  = 1'b1;
        rif.alloc_entry  = mk(8'h23, 1'b0, 1'b0, 8'h00);
        #1;
        chk("mp_commit_valid", rif.commit_valid, 1);
        chk("mp_commit_pc", rif.commit_entry.pc, 8'h20);
        chk("mp_flush_pre", rif.flush, 0);
        tick();
        #1;
        chk("mp_flush", rif.flush, 1);
        chk("mp_redirect", rif.redirect_pc, 8'h40);
        chk("mp_empty", rif.rob_empty, 1);
        chk("mp_count", rif.rob_count, 0);
        chk("mp_no_younger", rif.commit_valid, 0);
        chk("mp_alloc_blocked", rif.alloc_ready, 0);
        tick();
        idle();
        exp_tag = '0;
        #1;
        chk("mp_flush_clear", rif.flush, 0);
        chk("mp_empty_after", rif.rob_empty, 1);
        chk("mp_no_commit_after", rif.commit_valid, 0);
        chk("mp_ready_after", rif.alloc_ready, 1);
        chk("mp_tag_after", rif.alloc_tag, 0);
        rif.commit_ready = 1'b0;

        // Predicted taken at pc 0xFF, resolved not taken: redirect wraps to 0.
        alloc(mk(8'hFF, 1'b1, 1'b1, 8'h10));
        wb(rob_tag_t'(0), 32'h0, 1'b0, 8'h33);
        rif.commit_ready = 1'b1;
        #1;
        chk("nt_commit_valid", rif.commit_valid, 1);
        tick();
        #1;
        chk("nt_flush", rif.flush, 1);
        chk("nt_redirect", rif.redirect_pc, 8'h00);
        tick();
        rif.commit_ready = 1'b0;
        exp_tag = '0;

        // Correct taken prediction, then correct not-taken with stale target.
        alloc(mk(8'h30, 1'b1, 1'b1, 8'h44));
        alloc(mk(8'h31, 1'b1, 1'b0, 8'h99));
        wb(rob_tag_t'(0), 32'h0, 1'b1, 8'h44);
        wb(rob_tag_t'(1), 32'h0, 1'b0, 8'h55);
        commit_one(8'h30, 32'h0);
        #1;
        chk("ok_taken_no_flush", rif.flush, 0);
        commit_one(8'h31, 32'h0);
        #1;
        chk("ok_nt_no_flush", rif.flush, 0);
        chk("ok_empty", rif.rob_empty, 1);

        // Reset mid-stream with five live entries.
        t = exp_tag;
        for (int i = 0; i < 5; i++) alloc(mk(8'h90 + 8'(i), 1'b0, 1'b0, 8'h00));
        wb(t, 32'h90, 1'b0, 8'h00);
        #1;
        chk("mr_count_pre", rif.rob_count, 5);
        chk("mr_commit_pre", rif.commit_valid, 1);
        rst = 1'b1;
        #1;
        chk("mr_count", rif.rob_count, 0);
        chk("mr_commit", rif.commit_valid, 0);
        chk("mr_ready", rif.alloc_ready, 0);
        tick();
        rst = 1'b0;
        exp_tag = '0;
        #1;
        chk("mr_ready_after", rif.alloc_ready, 1);
        chk("mr_tag_after", rif.alloc_tag, 0);

        // Reset while a flush is pending.
        alloc(mk(8'h20, 1'b1, 1'b0, 8'h21));
        for (int i = 1; i < 5; i++) alloc(mk(8'h20 + 8'(i), 1'b0, 1'b0, 8'h00));
        wb(rob_tag_t'(0), 32'h0, 1'b1, 8'h40);
        rif.commit_ready = 1'b1;
        tick();
        #1;
        chk("pf_flush_pending", rif.flush, 1);
        rst = 1'b1;
        #1;
        chk("pf_flush_dropped", rif.flush, 0);
        chk("pf_count", rif.rob_count, 0);
        chk("pf_commit", rif.commit_valid, 0);
        rif.commit_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_tag = '0;
        #1;
        chk("pf_flush_after", rif.flush, 0);
        chk("pf_ready_after", rif.alloc_ready, 1);
        chk("pf_tag_after", rif.alloc_tag, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
